ysyx_22040237_ifu: RTL and testbench

- Instruction fetch unit; the producer end of the pc/inst interface consumed by the decode stage.
- Holds the architectural PC and issues word fetches to instruction memory over a valid/ready request plus valid response channel.
- Presents {pc, inst} to decode with a valid/ready handshake.
- Accepts jal/jalr redirects from the execute stage and discards stale in-flight fetches.

---
 rtl/ysyx_22040237_ifu.sv | 140 ++++++++++++++
 tb/tb_ysyx_22040237_ifu.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040237_ifu.sv
// ysyx_22040237_ifu: instruction fetch unit.
// Holds the architectural PC, fetches one word at a time from instruction
// memory (valid/ready request, valid-only response) and presents {pc, inst}
// to decode with a valid/ready handshake. jal/jalr redirects from execute
// override sequential flow and squash any stale fetch or held instruction.
// Optional: define YSYX_22040237_IFU_HALT_EN to add a sticky halt
// (halt_req/halted ports) that stops new fetch requests.
module ysyx_22040237_ifu #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [31:0]     out_inst,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc
`ifdef YSYX_22040237_IFU_HALT_EN
    ,
    input  logic            halt_req,
    output logic            halted
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [PC_W-1:0] r_pc;
    logic            r_kill;       // the single outstanding fetch is stale
    logic            r_out_valid;
    logic [PC_W-1:0] r_out_pc;
    logic [31:0]     r_out_inst;
    logic [PC_W-1:0] w_target;
    logic            w_hs;
    logic            w_halted;
    logic            w_unused;

    assign w_target = {redirect_pc[PC_W-1:2], 2'b00};
    assign w_unused = ^redirect_pc[1:0];
    assign w_hs     = imem_req_valid & imem_req_ready;

    assign out_valid = r_out_valid;
    assign out_pc    = r_out_pc;
    assign out_inst  = r_out_inst;

`ifdef YSYX_22040237_IFU_HALT_EN
    logic r_halted;

    // Sticky halt flag; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_halted <= 1'b0;
        else if (halt_req) r_halted <= 1'b1;
    end

    assign w_halted = r_halted;
    assign halted   = r_halted;
`else
    assign w_halted = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state: a redirect never lets a fetch reach HOLD or stay in HOLD.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: w_next = REQ;
            REQ:  if (w_hs) w_next = WAIT;
            WAIT: if (imem_resp_valid) w_next = (r_kill || redirect_valid) ? REQ : HOLD;
            HOLD: if (redirect_valid || out_ready) w_next = REQ;
            default: w_next = IDLE;
        endcase
    end

    // Request outputs; halting only suppresses new requests.
    always_comb begin
        imem_req_valid = (r_state == REQ) && !w_halted;
        imem_addr      = r_pc;
    end

    // PC: redirect beats the sequential step taken when decode consumes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_pc <= RESET_PC;
        else if (redirect_valid)
            r_pc <= w_target;
        else if (r_state == HOLD && out_ready)
            r_pc <= r_pc + PC_W'(4);
    end

    // Kill bit: marks the in-flight fetch as belonging to the old path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_kill <= 1'b0;
        end else begin
            case (r_state)
                REQ:  if (w_hs && redirect_valid) r_kill <= 1'b1;
                WAIT: begin
                    if (imem_resp_valid)     r_kill <= 1'b0;
                    else if (redirect_valid) r_kill <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Output register: capture a live response, release on consume or squash.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_pc    <= '0;
            r_out_inst  <= '0;
        end else begin
            case (r_state)
                WAIT: begin
                    if (imem_resp_valid && !r_kill && !redirect_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_pc    <= r_pc;
                        r_out_inst  <= imem_resp_data;
                    end
                end
                HOLD: if (redirect_valid || out_ready) r_out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040237_ifu.sv
// Bench for ysyx_22040237_ifu: directed scenarios followed by a randomized
// phase. A memory model answers fetches; a monitor keeps the expected
// program-order PC stream in a queue and checks every delivered instruction.
module tb_ysyx_22040237_ifu;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
`ifdef YSYX_22040237_IFU_HALT_EN
    logic        halt_req = 1'b0;
    logic        halted;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ndeliv = 0;
    int lat_fix = 1;        // 0: random latency, else fixed response latency
    bit rdy_fix = 1'b1;     // memory always ready
    bit late_resp = 1'b0;   // inject a spurious response

    logic [31:0] exp_q[$];  // expected PC of next delivered instruction
    logic [31:0] hs_log[$];
    int          hs_cyc[$];
    int          val_cyc[$];

    ysyx_22040237_ifu #(.PC_W(32), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef YSYX_22040237_IFU_HALT_EN
        , .halt_req(halt_req), .halted(halted)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8000_000C) return 32'h0010_0093;
        return {a[15:0] ^ 16'hA5C3, a[31:16] ^ a[15:0]};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic wait_hs(input int n);
        int k = 0;
        while (hs_log.size() < n && k < 200) begin @(negedge clk); #3; k++; end
        if (hs_log.size() < n) check("hs_timeout", 32'(hs_log.size()), 32'(n));
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!out_valid && k < 200) begin @(negedge clk); #3; k++; end
        if (!out_valid) check("valid_timeout", 32'(out_valid), 32'd1);
    endtask

    // Memory: one response per accepted request after a latency of >= 1 cycle.
    initial begin
        int wc;
        logic pend;
        logic [31:0] pa;
        pend = 1'b0; wc = 0; pa = '0;
        forever begin
            @(negedge clk); #1;
            if (rst) begin
                pend = 1'b0; imem_resp_valid = 1'b0; imem_req_ready = 1'b0;
            end else begin
                imem_resp_valid = 1'b0;
                if (late_resp) begin
                    imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
                end else if (pend) begin
                    if (wc == 0) begin
                        imem_resp_valid = 1'b1; imem_resp_data = mem_word(pa); pend = 1'b0;
                    end else wc--;
                end
                imem_req_ready = rdy_fix ? 1'b1 : 1'($urandom_range(0, 1));
                if (imem_req_valid && imem_req_ready) begin
                    check("one_outstanding", 32'(pend), 32'd0);
                    pend = 1'b1; pa = imem_addr;
                    wc = (lat_fix != 0) ? lat_fix - 1 : int'($urandom_range(0, 3));
                    hs_log.push_back(imem_addr); hs_cyc.push_back(cyc);
                end
            end
        end
    end

    // Monitor: program-order model; a redirect restarts the stream at the target.
    initial begin
        logic pv, pr, prd;
        logic [31:0] ppc, pin, e;
        pv = 1'b0; pr = 1'b0; prd = 1'b0; ppc = '0; pin = '0;
        forever begin
            @(negedge clk); #2;
            if (rst) begin
                exp_q.delete(); exp_q.push_back(RESET_PC); pv = 1'b0;
            end else begin
                if (out_valid) check("no_fetch_while_holding", 32'(imem_req_valid), 32'd0);
                if (pv && !pr && !prd) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_pc", out_pc, ppc);
                    check("hold_inst", out_inst, pin);
                end
                if (out_valid && !pv) val_cyc.push_back(cyc);
                if (redirect_valid) begin
                    exp_q.delete(); exp_q.push_back({redirect_pc[31:2], 2'b00});
                end else if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) check("exp_empty", 32'd1, 32'd0);
                    else begin
                        e = exp_q.pop_front();
                        check("out_pc", out_pc, e);
                        check("out_inst", out_inst, mem_word(e));
                        exp_q.push_back(e + 32'd4);
                    end
                    ndeliv++;
                end
                pv = out_valid; pr = out_ready; prd = redirect_valid; ppc = out_pc; pin = out_inst;
            end
        end
    end

    initial begin
        int n, rc, k;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #3;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_inst", out_inst, 32'd0);
        check("rst_addr", imem_addr, RESET_PC);
        @(negedge clk); rst = 1'b0;

        // Sequential fetch, 1-cycle memory, decode always ready.
        wait_hs(3);
        for (int i = 0; i < 3; i++) check("seq_addr", hs_log[i], RESET_PC + 32'(4 * i));
        k = 0;
        while (val_cyc.size() < 3 && k < 50) begin @(negedge clk); #3; k++; end
        for (int i = 0; i < 3; i++) check("latency", 32'(val_cyc[i] - hs_cyc[i]), 32'd2);

        // Backpressure for 5 cycles in HOLD.
        @(negedge clk); out_ready = 1'b0;
        wait_valid();
        repeat (5) @(negedge clk);
        out_ready = 1'b1;

        // Redirect while the fetch is outstanding.
        lat_fix = 3;
        n = hs_log.size();
        wait_hs(n + 1);
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h8000_0103;
        @(negedge clk); redirect_valid = 1'b0;
        wait_hs(n + 2);
        check("wait_redirect_addr", hs_log[n + 1], 32'h8000_0100);

        // Redirect while holding, decode ready the same cycle.
        @(negedge clk); out_ready = 1'b0;
        wait_valid();
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h8000_0200; out_ready = 1'b1;
        n = hs_log.size();
        @(negedge clk); redirect_valid = 1'b0;
        #3 check("hold_squash", 32'(out_valid), 32'd0);
        wait_hs(n + 1);
        check("hold_redirect_addr", hs_log[n], 32'h8000_0200);

        // Redirect coincident with a request handshake.
        lat_fix = 1;
        n = hs_log.size();
        wait_hs(n + 1);
        repeat (3) @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0040; rc = cyc;
        @(negedge clk); redirect_valid = 1'b0;
        wait_hs(n + 3);
        check("coincide_cycle", 32'(hs_cyc[n + 1]), 32'(rc));
        check("coincide_addr", hs_log[n + 2], 32'h8000_0040);

        // Asynchronous reset while waiting, then a stray late response.
        lat_fix = 3;
        n = hs_log.size();
        wait_hs(n + 1);
        @(negedge clk); #3 rst = 1'b1;
        #1;
        check("arst_req_valid", 32'(imem_req_valid), 32'd0);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_pc", out_pc, 32'd0);
        check("arst_out_inst", out_inst, 32'd0);
        check("arst_addr", imem_addr, RESET_PC);
        lat_fix = 1;
        repeat (2) @(negedge clk);
        rst = 1'b0; late_resp = 1'b1;
        n = hs_log.size(); rc = ndeliv;
        @(negedge clk); late_resp = 1'b0;
        wait_hs(n + 1);
        check("post_reset_addr", hs_log[n], RESET_PC);
        k = 0;
        while (ndeliv == rc && k < 50) begin @(negedge clk); #3; k++; end
        check("post_reset_deliver", 32'(ndeliv > rc), 32'd1);

        // Randomized traffic: random latency, ready, backpressure and redirects.
        lat_fix = 0; rdy_fix = 1'b0;
        rc = ndeliv;
        repeat (3000) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                      : $urandom;
        end
        @(negedge clk); redirect_valid = 1'b0; out_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("random_progress", 32'(ndeliv - rc > 100), 32'd1);

`ifdef YSYX_22040237_IFU_HALT_EN
        #3 check("halted_init", 32'(halted), 32'd0);
        @(negedge clk); halt_req = 1'b1;
        @(negedge clk); halt_req = 1'b0;
        #3 check("halted_set", 32'(halted), 32'd1);
        n = hs_log.size();
        repeat (20) @(negedge clk);
        #3 check("halt_no_fetch", 32'(hs_log.size()), 32'(n));
        check("halted_sticky", 32'(halted), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
